// File: rtl/booth_mul_scheduler.sv
// Round-robin front end that shares one start/done Booth multiplier among N_REQ
// requesters and returns tagged signed products, with a watchdog on the wait.
module booth_mul_scheduler #(
  parameter int N_REQ   = 2,
  parameter int ID_W    = 1,
  parameter int TIMEOUT = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req_valid,
  output logic [N_REQ-1:0]   o_req_ready,
  input  logic [4*N_REQ-1:0] i_req_a,
  input  logic [4*N_REQ-1:0] i_req_b,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [ID_W-1:0]    o_rsp_id,
  output logic [7:0]         o_rsp_data,
  output logic               o_rsp_err,
  output logic               o_busy,
  output logic               o_mul_start,
  output logic [4:0]         o_mul_op1,
  output logic [3:0]         o_mul_op2,
  input  logic               i_mul_done,
  input  logic [4:0]         i_mul_acc,
  input  logic [4:0]         i_mul_q
);

  localparam int unsigned NR    = N_REQ;
  localparam int          CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [ID_W-1:0]  last;
  logic [CNT_W-1:0] count;

  logic             found;
  logic [ID_W-1:0]  grant_id;
  logic [3:0]       grant_a;
  logic [3:0]       grant_b;
  logic [N_REQ-1:0] pick;

  // Only the low nibbles of ACC/Q form the 8-bit product.
  logic mul_unused;
  assign mul_unused = ^{i_mul_acc[4], i_mul_q[4]};

  // Round-robin: lowest valid index above last wins, otherwise wrap to the
  // lowest valid index at or below last.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    grant_a  = '0;
    grant_b  = '0;
    pick     = '0;
    for (int unsigned j = 0; j < NR; j++) begin
      if (!found && i_req_valid[j] && j > 32'(last)) begin
        found    = 1'b1;
        grant_id = ID_W'(j);
        grant_a  = i_req_a[4*j +: 4];
        grant_b  = i_req_b[4*j +: 4];
        pick[j]  = 1'b1;
      end
    end
    for (int unsigned j = 0; j < NR; j++) begin
      if (!found && i_req_valid[j] && j <= 32'(last)) begin
        found    = 1'b1;
        grant_id = ID_W'(j);
        grant_a  = i_req_a[4*j +: 4];
        grant_b  = i_req_b[4*j +: 4];
        pick[j]  = 1'b1;
      end
    end
    o_req_ready = (state == IDLE) ? pick : '0;
  end

  // The op registers double as the operand holding registers and last
  // doubles as the ID of the job in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      last        <= ID_W'(N_REQ - 1);
      count       <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_id    <= '0;
      o_rsp_data  <= '0;
      o_mul_start <= 1'b0;
      o_mul_op1   <= '0;
      o_mul_op2   <= '0;
      o_busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            o_mul_op1   <= {grant_a[3], grant_a};
            o_mul_op2   <= grant_b;
            last        <= grant_id;
            o_mul_start <= 1'b1;
            o_busy      <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          o_mul_start <= 1'b0;
          count       <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          count <= count + CNT_W'(1);
          if (i_mul_done) begin
            o_rsp_data  <= {i_mul_acc[3:0], i_mul_q[3:0]};
            o_rsp_err   <= 1'b0;
            o_rsp_id    <= last;
            o_rsp_valid <= 1'b1;
            state       <= RESP;
          end else if (count == CNT_W'(TIMEOUT - 1)) begin
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b1;
            o_rsp_id    <= last;
            o_rsp_valid <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_busy      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_scheduler.sv
// Directed bench for booth_mul_scheduler with a behavioural start/done multiplier.
module tb_booth_mul_scheduler;

  localparam int N_REQ   = 2;
  localparam int ID_W    = 1;
  localparam int TIMEOUT = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [4*N_REQ-1:0] req_a;
  logic [4*N_REQ-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [ID_W-1:0]  rsp_id;
  logic [7:0]       rsp_data;
  logic             rsp_err;
  logic             busy;
  logic             mul_start;
  logic [4:0]       mul_op1;
  logic [3:0]       mul_op2;
  logic             mul_done;
  logic [4:0]       mul_acc;
  logic [4:0]       mul_q;

  int vectors     = 0;
  int miscompares = 0;

  // multiplier model controls
  int    mul_lat    = 6;
  logic  mul_hang   = 1'b0;
  logic  force_done = 1'b0;
  logic  model_done = 1'b0;
  logic  pend       = 1'b0;
  int    cnt        = 0;
  logic signed [7:0] p;

  // monitors
  int   grant_q[$];
  logic [7:0] rsp_data_q[$];
  int   start_cnt     = 0;
  int   ready_run     = 0;
  int   ready_run_max = 0;

  always #5 clk = ~clk;

  booth_mul_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_id    (rsp_id),
    .o_rsp_data  (rsp_data),
    .o_rsp_err   (rsp_err),
    .o_busy      (busy),
    .o_mul_start (mul_start),
    .o_mul_op1   (mul_op1),
    .o_mul_op2   (mul_op2),
    .i_mul_done  (mul_done),
    .i_mul_acc   (mul_acc),
    .i_mul_q     (mul_q)
  );

  assign mul_done = model_done | force_done;

  // Multiplier: latches operands on start, raises done mul_lat cycles later.
  always @(negedge clk) begin
    model_done = 1'b0;
    if (mul_start && !mul_hang) begin
      pend    = 1'b1;
      cnt     = mul_lat - 1;
      p       = $signed(mul_op1) * $signed({mul_op2[3], mul_op2});
      mul_acc = {p[7], p[7:4]};
      mul_q   = {1'b0, p[3:0]};
    end else if (pend) begin
      if (cnt == 0) begin
        model_done = 1'b1;
        pend       = 1'b0;
      end else begin
        cnt = cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mul_start) start_cnt++;
    for (int j = 0; j < N_REQ; j++)
      if (req_valid[j] && req_ready[j]) grant_q.push_back(j);
    if (rsp_valid && rsp_ready) rsp_data_q.push_back(rsp_data);
    if (|req_ready) begin
      ready_run++;
      if (ready_run > ready_run_max) ready_run_max = ready_run;
    end else begin
      ready_run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_job(input int r, input logic [3:0] a, input logic [3:0] b,
                        output logic got, output logic [ID_W-1:0] id,
                        output logic [7:0] data, output logic err);
    req_valid[r]      = 1'b1;
    req_a[4*r +: 4]   = a;
    req_b[4*r +: 4]   = b;
    #1;
    for (int k = 0; k < 50 && !req_ready[r]; k++) tick();
    tick();
    req_valid[r] = 1'b0;
    for (int k = 0; k < 200 && !rsp_valid; k++) tick();
    got  = rsp_valid;
    id   = rsp_id;
    data = rsp_data;
    err  = rsp_err;
    tick();
  endtask

  task automatic test_reset();
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    do_reset();
    vectors++;
    if ({rsp_valid, rsp_err, rsp_id, rsp_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_rsp got v=%b e=%b id=%0d d=%h exp all 0", rsp_valid, rsp_err, rsp_id, rsp_data);
    end
    vectors++;
    if ({mul_start, mul_op1, mul_op2} !== '0) begin
      miscompares++;
      $display("FAIL reset_mul got start=%b op1=%h op2=%h exp all 0", mul_start, mul_op1, mul_op2);
    end
    vectors++;
    if ({busy, req_ready} !== '0) begin
      miscompares++;
      $display("FAIL reset_busy_ready got busy=%b ready=%b exp 0", busy, req_ready);
    end
  endtask

  task automatic test_single();
    logic [ID_W-1:0] id;
    int s0;
    mul_lat = 6;
    rsp_ready = 1'b1;
    s0 = start_cnt;
    req_valid = 2'b01; req_a[3:0] = 4'hD; req_b[3:0] = 4'h5;
    #1;
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++; $display("FAIL single_ready got=%b exp=01", req_ready);
    end
    tick();
    req_valid = '0;
    vectors++;
    if ({mul_start, mul_op1, mul_op2, busy} !== {1'b1, 5'h1D, 4'h5, 1'b1}) begin
      miscompares++;
      $display("FAIL single_issue got start=%b op1=%h op2=%h busy=%b exp 1 1d 5 1", mul_start, mul_op1, mul_op2, busy);
    end
    tick();
    vectors++;
    if ({mul_start, mul_op1, mul_op2} !== {1'b0, 5'h1D, 4'h5}) begin
      miscompares++;
      $display("FAIL single_wait got start=%b op1=%h op2=%h exp 0 1d 5", mul_start, mul_op1, mul_op2);
    end
    for (int k = 0; k < 100 && !rsp_valid; k++) tick();
    id = rsp_id;
    vectors++;
    if ({rsp_valid, id, rsp_data, rsp_err} !== {1'b1, 1'b0, 8'hF1, 1'b0}) begin
      miscompares++;
      $display("FAIL single_rsp got v=%b id=%0d d=%h e=%b exp 1 0 f1 0", rsp_valid, id, rsp_data, rsp_err);
    end
    tick();
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL single_rsp_drop got=%b exp=0", rsp_valid);
    end
    vectors++;
    if (start_cnt - s0 !== 1) begin
      miscompares++; $display("FAIL single_start_count got=%0d exp=1", start_cnt - s0);
    end
  endtask

  task automatic test_corner();
    logic got, err;
    logic [ID_W-1:0] id;
    logic [7:0] data;
    logic [3:0] av [3] = '{4'h8, 4'h7, 4'h0};
    logic [3:0] bv [3] = '{4'h8, 4'h8, 4'hF};
    logic [7:0] ev [3] = '{8'h40, 8'hC8, 8'h00};
    mul_lat = 3;
    for (int i = 0; i < 3; i++) begin
      do_job(i % 2, av[i], bv[i], got, id, data, err);
      vectors++;
      if ({got, data, err} !== {1'b1, ev[i], 1'b0}) begin
        miscompares++;
        $display("FAIL corner_%0d got v=%b d=%h e=%b exp 1 %h 0", i, got, data, err, ev[i]);
      end
    end
  endtask

  task automatic test_contention();
    int g;
    logic [7:0] d;
    do_reset();
    mul_lat = 3;
    rsp_ready = 1'b1;
    grant_q.delete();
    rsp_data_q.delete();
    ready_run_max = 0;
    req_a = {4'hF, 4'h2};
    req_b = {4'h4, 4'h3};
    req_valid = 2'b11;
    for (int k = 0; k < 400 && grant_q.size() < 4; k++) tick();
    req_valid = '0;
    for (int k = 0; k < 200 && busy; k++) tick();
    for (int i = 0; i < 4; i++) begin
      g = (i < grant_q.size()) ? grant_q[i] : -1;
      d = (i < rsp_data_q.size()) ? rsp_data_q[i] : 8'hXX;
      vectors++;
      if (g !== i % 2) begin
        miscompares++; $display("FAIL contention_grant_%0d got=%0d exp=%0d", i, g, i % 2);
      end
      vectors++;
      if (d !== ((i % 2 == 0) ? 8'h06 : 8'hFC)) begin
        miscompares++;
        $display("FAIL contention_data_%0d got=%h exp=%h", i, d, (i % 2 == 0) ? 8'h06 : 8'hFC);
      end
    end
    vectors++;
    if (ready_run_max !== 1) begin
      miscompares++; $display("FAIL contention_ready_pulse got=%0d exp=1", ready_run_max);
    end
    grant_q.delete();
    req_valid = 2'b10;
    for (int k = 0; k < 200 && grant_q.size() < 2; k++) tick();
    req_valid = '0;
    for (int k = 0; k < 200 && busy; k++) tick();
    for (int i = 0; i < 2; i++) begin
      g = (i < grant_q.size()) ? grant_q[i] : -1;
      vectors++;
      if (g !== 1) begin
        miscompares++; $display("FAIL single_req1_grant_%0d got=%0d exp=1", i, g);
      end
    end
  endtask

  task automatic test_backpressure();
    mul_lat = 3;
    rsp_ready = 1'b0;
    req_a = {4'h1, 4'h3};
    req_b = {4'h1, 4'h3};
    req_valid = 2'b11;
    #1;
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++; $display("FAIL bp_first_grant got=%b exp=01", req_ready);
    end
    tick();
    req_valid[0] = 1'b0;
    for (int k = 0; k < 100 && !rsp_valid; k++) tick();
    vectors++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 8'h09}) begin
      miscompares++; $display("FAIL bp_rsp got v=%b id=%0d d=%h exp 1 0 09", rsp_valid, rsp_id, rsp_data);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if ({rsp_valid, rsp_id, rsp_data, req_ready, mul_start} !== {1'b1, 1'b0, 8'h09, 2'b00, 1'b0}) begin
        miscompares++;
        $display("FAIL bp_hold_%0d got v=%b id=%0d d=%h rdy=%b st=%b exp 1 0 09 00 0",
                 c, rsp_valid, rsp_id, rsp_data, req_ready, mul_start);
      end
    end
    rsp_ready = 1'b1;
    tick();
    vectors++;
    if ({rsp_valid, req_ready} !== {1'b0, 2'b10}) begin
      miscompares++; $display("FAIL bp_release got v=%b rdy=%b exp 0 10", rsp_valid, req_ready);
    end
    tick();
    req_valid = '0;
    for (int k = 0; k < 100 && !rsp_valid; k++) tick();
    vectors++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 8'h01}) begin
      miscompares++; $display("FAIL bp_second got v=%b id=%0d d=%h exp 1 1 01", rsp_valid, rsp_id, rsp_data);
    end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    logic got, err;
    logic [ID_W-1:0] id;
    logic [7:0] data;
    mul_hang = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 2'b01; req_a[3:0] = 4'h1; req_b[3:0] = 4'h2;
    #1;
    for (int k = 0; k < 50 && !req_ready[0]; k++) tick();
    tick();
    req_valid = '0;
    tick();
    n = 0;
    while (n < 200 && !rsp_valid) begin
      tick();
      n++;
    end
    vectors++;
    if (n !== TIMEOUT) begin
      miscompares++; $display("FAIL timeout_latency got=%0d exp=%0d", n, TIMEOUT);
    end
    vectors++;
    if ({rsp_valid, rsp_err, rsp_data, rsp_id} !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL timeout_rsp got v=%b e=%b d=%h id=%0d exp 1 1 00 0", rsp_valid, rsp_err, rsp_data, rsp_id);
    end
    tick();
    mul_hang = 1'b0;
    do_job(1, 4'hE, 4'hD, got, id, data, err);
    vectors++;
    if ({got, id, data, err} !== {1'b1, 1'b1, 8'h06, 1'b0}) begin
      miscompares++; $display("FAIL timeout_recover got v=%b id=%0d d=%h e=%b exp 1 1 06 0", got, id, data, err);
    end
  endtask

  task automatic test_reset_mid_wait();
    int nrsp;
    mul_hang = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 2'b01; req_a[3:0] = 4'h5; req_b[3:0] = 4'h5;
    #1;
    for (int k = 0; k < 50 && !req_ready[0]; k++) tick();
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    nrsp = rsp_data_q.size();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({rsp_valid, rsp_err, rsp_id, rsp_data, mul_start, mul_op1, mul_op2, busy, req_ready} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs got v=%b e=%b id=%0d d=%h st=%b op1=%h op2=%h busy=%b rdy=%b exp all 0",
               rsp_valid, rsp_err, rsp_id, rsp_data, mul_start, mul_op1, mul_op2, busy, req_ready);
    end
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    tick(); tick();
    vectors++;
    if ({rsp_valid, busy} !== 2'b00 || rsp_data_q.size() != nrsp) begin
      miscompares++;
      $display("FAIL midreset_stale_done got v=%b busy=%b rsps=%0d exp 0 0 %0d", rsp_valid, busy, rsp_data_q.size(), nrsp);
    end
    mul_hang = 1'b0;
    req_valid = 2'b11; req_a = {4'h2, 4'h5}; req_b = {4'h2, 4'h5};
    #1;
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++; $display("FAIL midreset_first_grant got=%b exp=01", req_ready);
    end
    tick();
    req_valid = '0;
    for (int k = 0; k < 100 && !rsp_valid; k++) tick();
    vectors++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 1'b0, 8'h19, 1'b0}) begin
      miscompares++;
      $display("FAIL midreset_job got v=%b id=%0d d=%h e=%b exp 1 0 19 0", rsp_valid, rsp_id, rsp_data, rsp_err);
    end
    tick();
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_corner();
    test_contention();
    test_backpressure();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit reached at %0t, expected bench to finish earlier", $time);
    $fatal(1);
  end

endmodule
